// File: rtl/k12_exec_ctrl.sv
// Multi-cycle fetch/execute sequencer for the K12 8-bit ALU datapath.
// Optional single-step mode is enabled by defining K12_EXEC_CTRL_SINGLE_STEP_EN.
module k12_exec_ctrl #(
    parameter logic [7:0] RESET_PC  = 8'h00,
    parameter logic [7:0] ACC_RESET = 8'h00
) (
    input  logic        clock,
    input  logic        reset,
`ifdef K12_EXEC_CTRL_SINGLE_STEP_EN
    input  logic        step,
`endif
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic [1:0]  rf_raddr,
    input  logic [7:0]  rf_rdata,
    output logic        rf_we,
    output logic [1:0]  rf_waddr,
    output logic [7:0]  rf_wdata,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [15:0] alu_inst,
    input  logic [7:0]  alu_res,
    input  logic        alu_cond,
    output logic [7:0]  pc,
    output logic        retired,
    output logic        halted
);

`ifdef K12_EXEC_CTRL_SINGLE_STEP_EN
    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT, S_STEP_WAIT} state_t;
`else
    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;
`endif

    state_t      r_state;
    logic [7:0]  r_pc;
    logic [7:0]  r_acc;
    logic [15:0] r_ir;

    logic [1:0]  w_class;
    logic        w_is_halt;
    logic [7:0]  w_pc_next;

    assign w_class   = r_ir[15:14];
    assign w_is_halt = (w_class == 2'b11) && r_ir[11];

    always_comb begin
        w_pc_next = r_pc + 8'd1;
        case (w_class)
            2'b01:   if (alu_cond) w_pc_next = r_pc + 8'd2;
            2'b11:   w_pc_next = r_ir[11] ? r_pc : r_ir[7:0];
            default: w_pc_next = r_pc + 8'd1;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_acc   <= ACC_RESET;
            r_ir    <= 16'h0000;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_ack) begin
                        r_ir    <= imem_data;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_pc <= w_pc_next;
                    if (w_class == 2'b00) r_acc <= alu_res;
                    if (w_is_halt)
                        r_state <= S_HALT;
                    else
`ifdef K12_EXEC_CTRL_SINGLE_STEP_EN
                        r_state <= S_STEP_WAIT;
`else
                        r_state <= S_FETCH;
`endif
                end
`ifdef K12_EXEC_CTRL_SINGLE_STEP_EN
                S_STEP_WAIT: begin
                    if (step) r_state <= S_FETCH;
                end
`endif
                default: r_state <= S_HALT;
            endcase
        end
    end

    // The reset term keeps the request low while reset is held, since the
    // state register already reads FETCH during that time.
    assign imem_req  = (r_state == S_FETCH) && !reset;
    assign imem_addr = r_pc;
    assign rf_raddr  = r_ir[1:0];
    assign rf_we     = (r_state == S_EXEC) && (w_class == 2'b10);
    assign rf_waddr  = r_ir[1:0];
    assign rf_wdata  = r_acc;
    assign alu_a     = r_acc;
    assign alu_b     = rf_rdata;
    assign alu_inst  = r_ir;
    assign pc        = r_pc;
    assign retired   = (r_state == S_EXEC) && !w_is_halt;
    assign halted    = (r_state == S_HALT);

endmodule

// File: tb/tb_k12_exec_ctrl.sv
// Directed table-driven bench for k12_exec_ctrl: the bench plays the
// instruction memory, ALU and register file.
module tb_k12_exec_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        step  = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack  = 1'b0;
    logic [15:0] imem_data = 16'h0000;
    logic [1:0]  rf_raddr;
    logic [7:0]  rf_rdata  = 8'h5A;
    logic        rf_we;
    logic [1:0]  rf_waddr;
    logic [7:0]  rf_wdata;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [15:0] alu_inst;
    logic [7:0]  alu_res   = 8'h00;
    logic        alu_cond  = 1'b0;
    logic [7:0]  pc;
    logic        retired;
    logic        halted;

    int n_tests = 0;
    int n_fail  = 0;

    k12_exec_ctrl #(.RESET_PC(8'h00), .ACC_RESET(8'h00)) dut (
        .clock(clock), .reset(reset),
`ifdef K12_EXEC_CTRL_SINGLE_STEP_EN
        .step(step),
`endif
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_data(imem_data), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_inst(alu_inst),
        .alu_res(alu_res), .alu_cond(alu_cond), .pc(pc),
        .retired(retired), .halted(halted)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] instr;
        logic [7:0]  res;
        logic        cond;
        logic        exp_we;
        logic [1:0]  exp_waddr;
        logic [7:0]  exp_wdata;
        logic        exp_ret;
        logic [7:0]  exp_pc;
        logic [7:0]  exp_acc;
        logic        exp_halt;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Runs one instruction from a FETCH cycle through its commit.
    task automatic run_vec(input vec_t v, input int idx);
        chk($sformatf("v%0d fetch_req", idx), {15'd0, imem_req}, 16'd1);
        chk($sformatf("v%0d fetch_retired", idx), {15'd0, retired}, 16'd0);
        chk($sformatf("v%0d fetch_we", idx), {15'd0, rf_we}, 16'd0);
        imem_data = v.instr;
        imem_ack  = 1'b1;
        alu_res   = v.res;
        alu_cond  = v.cond;
        tick();
        imem_ack  = 1'b0;
        chk($sformatf("v%0d exec_req", idx), {15'd0, imem_req}, 16'd0);
        chk($sformatf("v%0d exec_inst", idx), alu_inst, v.instr);
        chk($sformatf("v%0d exec_we", idx), {15'd0, rf_we}, {15'd0, v.exp_we});
        chk($sformatf("v%0d exec_retired", idx), {15'd0, retired}, {15'd0, v.exp_ret});
        if (v.exp_we) begin
            chk($sformatf("v%0d waddr", idx), {14'd0, rf_waddr}, {14'd0, v.exp_waddr});
            chk($sformatf("v%0d wdata", idx), {8'd0, rf_wdata}, {8'd0, v.exp_wdata});
            chk($sformatf("v%0d raddr", idx), {14'd0, rf_raddr}, {14'd0, v.exp_waddr});
            chk($sformatf("v%0d alu_b", idx), {8'd0, alu_b}, 16'h005A);
        end
        tick();
        chk($sformatf("v%0d pc", idx), {8'd0, pc}, {8'd0, v.exp_pc});
        chk($sformatf("v%0d acc", idx), {8'd0, alu_a}, {8'd0, v.exp_acc});
        chk($sformatf("v%0d halted", idx), {15'd0, halted}, {15'd0, v.exp_halt});
        chk($sformatf("v%0d post_we", idx), {15'd0, rf_we}, 16'd0);
        chk($sformatf("v%0d post_retired", idx), {15'd0, retired}, 16'd0);
`ifdef K12_EXEC_CTRL_SINGLE_STEP_EN
        if (!v.exp_halt) begin
            chk($sformatf("v%0d stepwait_req", idx), {15'd0, imem_req}, 16'd0);
            tick();
            chk($sformatf("v%0d stepwait_hold", idx), {15'd0, imem_req}, 16'd0);
            step = 1'b1;
            tick();
            step = 1'b0;
        end
`endif
        $display("[TB] vec %0d instr=%h pc=%h acc=%h ret=%0b we=%0b halted=%0b",
                 idx, v.instr, pc, alu_a, v.exp_ret, v.exp_we, halted);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #3;
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        //          instr     res    c  we  wa     wd     ret  pc     acc    halt
        vecs[0]  = '{16'h1405, 8'h05, 0, 0, 2'd0, 8'h00, 1, 8'h01, 8'h05, 0};
        vecs[1]  = '{16'h0000, 8'hA5, 0, 0, 2'd0, 8'h00, 1, 8'h02, 8'hA5, 0};
        vecs[2]  = '{16'hC010, 8'h77, 0, 0, 2'd0, 8'h00, 1, 8'h10, 8'hA5, 0};
        vecs[3]  = '{16'h4000, 8'h77, 1, 0, 2'd0, 8'h00, 1, 8'h12, 8'hA5, 0};
        vecs[4]  = '{16'h4000, 8'h77, 0, 0, 2'd0, 8'h00, 1, 8'h13, 8'hA5, 0};
        vecs[5]  = '{16'hC0FF, 8'h77, 0, 0, 2'd0, 8'h00, 1, 8'hFF, 8'hA5, 0};
        vecs[6]  = '{16'h8003, 8'h77, 1, 1, 2'd3, 8'hA5, 1, 8'h00, 8'hA5, 0};
        vecs[7]  = '{16'hC0FE, 8'h77, 0, 0, 2'd0, 8'h00, 1, 8'hFE, 8'hA5, 0};
        vecs[8]  = '{16'h4000, 8'h77, 1, 0, 2'd0, 8'h00, 1, 8'h00, 8'hA5, 0};
        vecs[9]  = '{16'hC0FF, 8'h77, 0, 0, 2'd0, 8'h00, 1, 8'hFF, 8'hA5, 0};
        vecs[10] = '{16'h4000, 8'h77, 1, 0, 2'd0, 8'h00, 1, 8'h01, 8'hA5, 0};
        vecs[11] = '{16'h0123, 8'h3C, 1, 0, 2'd0, 8'h00, 1, 8'h02, 8'h3C, 0};
        vecs[12] = '{16'hC07F, 8'h77, 0, 0, 2'd0, 8'h00, 1, 8'h7F, 8'h3C, 0};
        vecs[13] = '{16'hC800, 8'h77, 1, 0, 2'd0, 8'h00, 0, 8'h7F, 8'h3C, 1};

        #1;
        chk("reset_req", {15'd0, imem_req}, 16'd0);
        chk("reset_halted", {15'd0, halted}, 16'd0);
        chk("reset_pc", {8'd0, pc}, 16'h0000);
        apply_reset();
        chk("fetch_addr", {8'd0, imem_addr}, 16'h0000);
        chk("reset_acc", {8'd0, alu_a}, 16'h0000);

        for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

        // Halt is sticky: no requests, no retires, PC frozen.
        imem_ack = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("halt_req", {15'd0, imem_req}, 16'd0);
            chk("halt_retired", {15'd0, retired}, 16'd0);
            chk("halt_flag", {15'd0, halted}, 16'd1);
            chk("halt_pc", {8'd0, pc}, 16'h007F);
            tick();
        end
        imem_ack = 1'b0;
        $display("[TB] halt hold 20 cycles pc=%h", pc);

        // Fetch stall followed by an asynchronous reset in the middle of a cycle.
        apply_reset();
        run_vec('{16'hC055, 8'h77, 0, 0, 2'd0, 8'h00, 1, 8'h55, 8'h00, 0}, 20);
        run_vec('{16'h0000, 8'h42, 0, 0, 2'd0, 8'h00, 1, 8'h56, 8'h42, 0}, 21);
        for (int i = 0; i < 5; i++) begin
            chk("stall_req", {15'd0, imem_req}, 16'd1);
            chk("stall_addr", {8'd0, imem_addr}, 16'h0056);
            tick();
        end
        #3;
        reset = 1'b1;
        #1;
        chk("async_pc", {8'd0, pc}, 16'h0000);
        chk("async_acc", {8'd0, alu_a}, 16'h0000);
        chk("async_req", {15'd0, imem_req}, 16'd0);
        $display("[TB] async reset mid-stall pc=%h acc=%h", pc, alu_a);
        tick();
        reset = 1'b0;
        #1;

        // Reset during EXEC discards the instruction.
        run_vec('{16'hC033, 8'h77, 0, 0, 2'd0, 8'h00, 1, 8'h33, 8'h00, 0}, 22);
        imem_data = 16'h0000;
        alu_res   = 8'h99;
        imem_ack  = 1'b1;
        tick();
        imem_ack  = 1'b0;
        chk("midexec_retired", {15'd0, retired}, 16'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("midexec_retired_rst", {15'd0, retired}, 16'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("midexec_pc", {8'd0, pc}, 16'h0000);
        chk("midexec_acc", {8'd0, alu_a}, 16'h0000);
        chk("midexec_req", {15'd0, imem_req}, 16'd1);
        $display("[TB] reset mid-exec pc=%h acc=%h", pc, alu_a);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
